// File: rtl/ex_alu_if.sv
// Execute-stage ALU request/result bundle: operation request in, registered result and status out.
`timescale 1ns/1ps
interface ex_alu_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start_i;
    logic [2:0]       ALUCtrl_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic [WIDTH-1:0] data_o;
    logic             zero_o;
    logic             done_o;
    logic             busy_o;

    modport master (
        output start_i,
        output ALUCtrl_i,
        output data1_i,
        output data2_i,
        input  data_o,
        input  zero_o,
        input  done_o,
        input  busy_o
    );

    modport slave (
        input  start_i,
        input  ALUCtrl_i,
        input  data1_i,
        input  data2_i,
        output data_o,
        output zero_o,
        output done_o,
        output busy_o
    );
endinterface

// File: rtl/ex_alu.sv
// Execute-stage ALU: single-cycle AND/OR/ADD/SUB, iterative shift-add MUL that stalls the pipe via busy_o.
`timescale 1ns/1ps
module ex_alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic    clk_i,
    input  logic    rst_i,
    ex_alu_if.slave bus
);

    localparam int unsigned     CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_MUL = 3'b100
    } alu_op_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] acc_step;

    // Reserved codes (and MUL, which never takes this path) produce zero.
    always_comb begin
        alu_res = '0;
        case (bus.ALUCtrl_i)
            OP_AND:  alu_res = bus.data1_i & bus.data2_i;
            OP_OR:   alu_res = bus.data1_i | bus.data2_i;
            OP_ADD:  alu_res = bus.data1_i + bus.data2_i;
            OP_SUB:  alu_res = bus.data1_i - bus.data2_i;
            default: alu_res = '0;
        endcase
    end

    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        zero_d   = zero_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    if (bus.ALUCtrl_i == OP_MUL) begin
                        mcand_d  = bus.data1_i;
                        mplier_d = bus.data2_i;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = MUL;
                    end else begin
                        data_d = alu_res;
                        zero_d = (alu_res == '0);
                        done_d = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                // Final step publishes the accumulator including this edge's add.
                if (cnt_q == CNT_LAST) begin
                    data_d  = acc_step;
                    zero_d  = (acc_step == '0);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign bus.data_o = data_q;
    assign bus.zero_o = zero_q;
    assign bus.done_o = done_q;
    assign bus.busy_o = (state_q == MUL);

endmodule

// File: tb/tb_ex_alu.sv
// Directed self-checking bench for ex_alu: reset, single-cycle ops, MUL latency, busy stall, mid-MUL reset.
`timescale 1ns/1ps
module tb_ex_alu;

    logic clk_i;
    logic rst_i;
    int   n_cmp;
    int   n_err;

    ex_alu_if #(.WIDTH(32)) bus ();

    ex_alu #(.WIDTH(32)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.ALUCtrl_i = op;
        bus.data1_i   = a;
        bus.data2_i   = b;
        bus.start_i   = 1'b1;
    endtask

    // Issues a MUL, then counts busy cycles until it drops (bounded).
    task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                          output int cyc, output bit done_early);
        set_op(3'b100, a, b);
        tick();
        bus.start_i = 1'b0;
        cyc         = 0;
        done_early  = 1'b0;
        while (bus.busy_o && cyc < 100) begin
            if (bus.done_o) done_early = 1'b1;
            tick();
            cyc++;
        end
    endtask

    int cyc;
    bit early;
    bit done_seen;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_i         = 1'b0;
        bus.start_i   = 1'b0;
        bus.ALUCtrl_i = 3'b000;
        bus.data1_i   = '0;
        bus.data2_i   = '0;

        // Reset
        tick();
        tick();
        chk("rst_data", bus.data_o, 32'h0);
        chk("rst_zero", {31'b0, bus.zero_o}, 32'h1);
        chk("rst_done", {31'b0, bus.done_o}, 32'h0);
        chk("rst_busy", {31'b0, bus.busy_o}, 32'h0);
        rst_i = 1'b1;
        tick();
        chk("post_rst_data", bus.data_o, 32'h0);
        chk("post_rst_zero", {31'b0, bus.zero_o}, 32'h1);
        chk("post_rst_done", {31'b0, bus.done_o}, 32'h0);

        // Back-to-back single-cycle ops
        set_op(3'b010, 32'h7FFF_FFFF, 32'h1);
        tick();
        chk("add_data", bus.data_o, 32'h8000_0000);
        chk("add_zero", {31'b0, bus.zero_o}, 32'h0);
        chk("add_done", {31'b0, bus.done_o}, 32'h1);
        chk("add_busy", {31'b0, bus.busy_o}, 32'h0);
        set_op(3'b011, 32'd5, 32'd5);
        tick();
        chk("sub_data", bus.data_o, 32'h0);
        chk("sub_zero", {31'b0, bus.zero_o}, 32'h1);
        chk("sub_done", {31'b0, bus.done_o}, 32'h1);
        chk("sub_busy", {31'b0, bus.busy_o}, 32'h0);
        set_op(3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        tick();
        chk("and_data", bus.data_o, 32'h00F0_00F0);
        chk("and_done", {31'b0, bus.done_o}, 32'h1);
        chk("and_busy", {31'b0, bus.busy_o}, 32'h0);
        set_op(3'b001, 32'h1, 32'h2);
        tick();
        chk("or_data", bus.data_o, 32'h3);
        chk("or_done", {31'b0, bus.done_o}, 32'h1);
        bus.start_i = 1'b0;
        tick();
        chk("hold_data", bus.data_o, 32'h3);
        chk("hold_done", {31'b0, bus.done_o}, 32'h0);

        set_op(3'b011, 32'd3, 32'd5);
        tick();
        bus.start_i = 1'b0;
        chk("sub_neg_data", bus.data_o, 32'hFFFF_FFFE);

        // MUL 7x6
        do_mul(32'd7, 32'd6, cyc, early);
        chk("mul7x6_busy_cycles", 32'(cyc), 32'd32);
        chk("mul7x6_early_done", {31'b0, early}, 32'h0);
        chk("mul7x6_data", bus.data_o, 32'd42);
        chk("mul7x6_zero", {31'b0, bus.zero_o}, 32'h0);
        chk("mul7x6_done", {31'b0, bus.done_o}, 32'h1);
        tick();
        chk("mul7x6_done_pulse", {31'b0, bus.done_o}, 32'h0);
        chk("mul7x6_hold", bus.data_o, 32'd42);

        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, early);
        chk("mul_ff_cycles", 32'(cyc), 32'd32);
        chk("mul_ff_data", bus.data_o, 32'h1);

        do_mul(32'h0001_0000, 32'h0001_0000, cyc, early);
        chk("mul_wrap_data", bus.data_o, 32'h0);
        chk("mul_wrap_zero", {31'b0, bus.zero_o}, 32'h1);

        do_mul(32'h1234_5678, 32'h9ABC_DEF1, cyc, early);
        chk("mul_mix_data", bus.data_o, 32'h1234_5678 * 32'h9ABC_DEF1);

        // Start while busy is ignored
        set_op(3'b100, 32'd3, 32'd4);
        tick();                               // E0
        bus.start_i = 1'b0;
        repeat (4) tick();                    // E1..E4
        set_op(3'b010, 32'd1, 32'd1);
        tick();                               // E5
        bus.start_i = 1'b0;
        chk("busy_ign1_busy", {31'b0, bus.busy_o}, 32'h1);
        chk("busy_ign1_data", bus.data_o, 32'h1234_5678 * 32'h9ABC_DEF1);
        chk("busy_ign1_done", {31'b0, bus.done_o}, 32'h0);
        repeat (26) tick();                   // E6..E31
        set_op(3'b010, 32'd1, 32'd1);
        tick();                               // E32
        chk("busy_ign2_data", bus.data_o, 32'd12);
        chk("busy_ign2_done", {31'b0, bus.done_o}, 32'h1);
        chk("busy_ign2_busy", {31'b0, bus.busy_o}, 32'h0);
        tick();                               // E33
        bus.start_i = 1'b0;
        chk("after_mul_add_data", bus.data_o, 32'd2);
        chk("after_mul_add_done", {31'b0, bus.done_o}, 32'h1);
        tick();
        chk("after_mul_add_pulse", {31'b0, bus.done_o}, 32'h0);

        // Reset mid-multiply
        set_op(3'b100, 32'd9, 32'd9);
        tick();
        bus.start_i = 1'b0;
        repeat (10) tick();
        chk("midrst_busy_before", {31'b0, bus.busy_o}, 32'h1);
        rst_i = 1'b0;
        #1;
        chk("midrst_busy", {31'b0, bus.busy_o}, 32'h0);
        chk("midrst_data", bus.data_o, 32'h0);
        chk("midrst_zero", {31'b0, bus.zero_o}, 32'h1);
        chk("midrst_done", {31'b0, bus.done_o}, 32'h0);
        tick();
        rst_i = 1'b1;
        done_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done_o || bus.busy_o) done_seen = 1'b1;
            tick();
        end
        chk("midrst_no_done", {31'b0, done_seen}, 32'h0);
        chk("midrst_data_hold", bus.data_o, 32'h0);
        do_mul(32'd2, 32'd3, cyc, early);
        chk("midrst_mul_cycles", 32'(cyc), 32'd32);
        chk("midrst_mul_data", bus.data_o, 32'd6);
        chk("midrst_mul_done", {31'b0, bus.done_o}, 32'h1);

        // Reserved op code
        set_op(3'b111, 32'h1234_5678, 32'h1);
        tick();
        bus.start_i = 1'b0;
        chk("rsv_data", bus.data_o, 32'h0);
        chk("rsv_zero", {31'b0, bus.zero_o}, 32'h1);
        chk("rsv_done", {31'b0, bus.done_o}, 32'h1);
        chk("rsv_busy", {31'b0, bus.busy_o}, 32'h0);
        tick();
        chk("rsv_done_pulse", {31'b0, bus.done_o}, 32'h0);
        chk("rsv_busy2", {31'b0, bus.busy_o}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
